// File: rtl/sand_mem_responder_pkg.sv
// sand_pkg: refresh FSM state type and default parameters shared by the sand_mem_responder files
package sand_pkg;
  typedef enum logic {ACTIVE, REFRESH} state_t;
  localparam int D_ADDR_W = 24;
  localparam int D_DEPTH = 4096;
  localparam int D_READ_LATENCY = 3;
  localparam int D_MAX_PENDING = 2;
  localparam int D_REFRESH_PERIOD = 1024;
  localparam int D_REFRESH_CYCLES = 8;
endpackage

// File: rtl/sand_mem_responder_if.sv
// sand_mem_responder_if: Avalon-MM style memory bus between a master and sand_mem_responder
//   master drives mem_address/mem_read/mem_write/mem_writedata
//   slave drives mem_waitrequest/mem_readdatavalid/mem_readdata/protocol_err
interface sand_mem_responder_if
  import sand_pkg::*;
#(
  parameter int ADDR_W = D_ADDR_W
);
  logic [ADDR_W-1:0] mem_address;
  logic mem_read;
  logic mem_write;
  logic [15:0] mem_writedata;
  logic mem_waitrequest;
  logic mem_readdatavalid;
  logic [15:0] mem_readdata;
  logic protocol_err;
  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input mem_waitrequest, mem_readdatavalid, mem_readdata, protocol_err
  );
  modport slave (
    input mem_address, mem_read, mem_write, mem_writedata,
    output mem_waitrequest, mem_readdatavalid, mem_readdata, protocol_err
  );
endinterface

// File: rtl/sand_mem_responder_ram.sv
// sand_ram_1p: 16-bit single-port synchronous RAM, write wins, 1-cycle registered read
//   clk: clock, i_we: write enable, i_addr: word address, i_wdata: write data, o_rdata: read data
module sand_ram_1p
  import sand_pkg::*;
#(
  parameter int DEPTH = D_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [15:0]              i_wdata,
  output logic [15:0]              o_rdata
);
  logic [15:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
    else o_rdata <= r_mem[i_addr];
endmodule

// File: rtl/sand_mem_responder.sv
// sand_mem_responder: Avalon-MM memory slave with fixed read latency, read throttling and refresh stalls
//   clock: rising-edge clock, reset: async active-low reset, bus: slave side of sand_mem_responder_if
module sand_mem_responder
  import sand_pkg::*;
#(
  parameter int ADDR_W = D_ADDR_W,
  parameter int DEPTH = D_DEPTH,
  parameter int READ_LATENCY = D_READ_LATENCY,
  parameter int MAX_PENDING = D_MAX_PENDING,
  parameter int REFRESH_PERIOD = D_REFRESH_PERIOD,
  parameter int REFRESH_CYCLES = D_REFRESH_CYCLES
) (
  input logic                  clock,
  input logic                  reset,
  sand_mem_responder_if.slave  bus
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam int CW = $clog2(REFRESH_CYCLES + 1);
  state_t r_state;
  logic [RW-1:0] r_ref_cnt;
  logic [CW-1:0] r_stall_cnt;
  logic [PW-1:0] r_pending;
  logic [READ_LATENCY:1] r_vld;
  logic r_oob;
  logic r_err;
  logic w_wait, w_acc, w_wr_acc, w_rd_acc, w_in_rng, w_wrap, w_stall_done;
  logic [15:0] w_q;
  logic [READ_LATENCY:1][15:0] w_stage;
  assign w_in_rng = {1'b0, bus.mem_address} < (ADDR_W + 1)'(DEPTH);
  assign w_wait = !reset || r_state == REFRESH || (bus.mem_read && r_pending == PW'(MAX_PENDING));
  assign w_acc = (bus.mem_read || bus.mem_write) && !w_wait;
  assign w_wr_acc = w_acc && bus.mem_write;
  // a simultaneous read+write is accepted as the write alone
  assign w_rd_acc = w_acc && !bus.mem_write;
  assign w_wrap = r_ref_cnt == RW'(REFRESH_PERIOD - 1);
  assign w_stall_done = r_stall_cnt == CW'(REFRESH_CYCLES - 1);
  sand_ram_1p #(.DEPTH(DEPTH)) u_ram (
    .clk(clock),
    .i_we(w_wr_acc && w_in_rng),
    .i_addr(bus.mem_address[$clog2(DEPTH)-1:0]),
    .i_wdata(bus.mem_writedata),
    .o_rdata(w_q)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= ACTIVE;
      r_ref_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + 1'b1;
      r_stall_cnt <= (r_state == REFRESH && !w_stall_done) ? r_stall_cnt + 1'b1 : '0;
      r_state <= r_state == ACTIVE ? (w_wrap ? REFRESH : ACTIVE) : (w_stall_done ? ACTIVE : REFRESH);
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_vld <= '0;
      r_oob <= 1'b0;
      r_err <= 1'b0;
      r_pending <= '0;
    end else begin
      r_vld <= {r_vld[READ_LATENCY-1:1], w_rd_acc};
      r_oob <= !w_in_rng;
      r_err <= r_err || (w_acc && (!w_in_rng || bus.mem_read && bus.mem_write));
      r_pending <= r_pending + PW'(w_rd_acc) - PW'(r_vld[READ_LATENCY]);
    end
  // stage 1 is the RAM output; out-of-range reads are forced to zero there
  assign w_stage[1] = r_oob ? 16'h0000 : w_q;
  for (genvar k = 2; k <= READ_LATENCY; k++) begin : g_stage
    logic [15:0] r_d;
    // stages only load behind a valid, so the last stage holds the previous return
    always_ff @(posedge clock or negedge reset)
      if (!reset) r_d <= '0;
      else if (r_vld[k-1]) r_d <= w_stage[k-1];
    assign w_stage[k] = r_d;
  end
  assign bus.mem_waitrequest = w_wait;
  assign bus.mem_readdatavalid = r_vld[READ_LATENCY];
  assign bus.mem_readdata = w_stage[READ_LATENCY];
  assign bus.protocol_err = r_err;
endmodule
